cla_pipe_addsub: RTL
====================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor that generalises the team's fixed 32-bit CLA. The operand width is split into STAGES equal slices. Each slice is a 4-bit-group two-level lookahead adder, and the carry between slices is registered, so slice k resolves in pipeline stage k. The block adds subtract and carry/borrow-chain modes, full NZCV flags and valid/ready flow control. It sits between the ALU operand muxes and the writeback register.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4*STAGES
- STAGES, 2, pipeline depth and slice count (1..8); slice width SW = WIDTH/STAGES
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op present
- in_ready  out  1  block accepts input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 A+B, 01 A-B, 10 A+B+cin, 11 A-B-~cin (borrow chain)
- cin  in  1  carry-in, used only for op[1]=1
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow)
- ovf  out  1  signed overflow
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

## Operation
- Effective operand: b_eff = op[0] ? ~b : b. Carry-in c0 = op[1] ? cin : op[0].
- Each slice computes per-bit P = a^b_eff and G = a&b_eff, 4-bit group PG/GG, slice-level lookahead carries, and sum bits.
- Slice carry-out = GG_slice | PG_slice & c_slice_in.
- Stage k (0-based) holds:
  - the registered carry into slice k+1;
  - sum bits already produced, slices 0..k;
  - the unprocessed upper operand bits (a, b_eff), delayed with the stage;
  - a running zero accumulator (AND of per-slice sum==0);
  - valid bit vk.
- Final stage drives sum, cout, zero and neg. It also drives ovf = (a[W-1] ~^ b_eff[W-1]) & (sum[W-1] ^ a[W-1]), with a[W-1] and b_eff[W-1] carried through the pipe.
- Flow control is a whole-pipe stall:
  - adv = ~out_valid | out_ready.
  - in_ready = adv (combinational from out_valid/out_ready only, not from in_valid).
  - When adv=1, every stage register loads from its predecessor, and stage 0 loads {inputs, in_valid}.
  - When adv=0, all stage registers hold.
- Bubbles propagate as valid=0. Bubble data registers may load but are don't-care; flags are qualified by out_valid.
- STAGES=1: single register stage; the combinational path is the full WIDTH lookahead.

## Timing
- Latency: a transfer accepted at edge n (in_valid & in_ready) yields out_valid with its result after edge n+STAGES-1, i.e. visible in the cycle after that edge, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one operation per cycle while out_ready=1.
- Output is registered. sum/flags stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and retire in the same cycle is legal and loses nothing.
- Reset (rst_n=0, asynchronous, any time, including mid-stream):
  - all vk=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0;
  - in-flight operations are discarded;
  - in_ready=1 while out_valid=0 after reset.
- Release of rst_n is synchronised externally. The first accept is possible on the first edge after release.
- Wrap-around: results are modulo 2^WIDTH. cout reports the dropped carry.

## Test plan
- Reset mid-stream: WIDTH=32, STAGES=2, three ops in flight, assert rst_n low. Required: out_valid=0 and all outputs 0 immediately. After release, the first new op emerges with no stale results.
- Carry across slices: a=0x0000FFFF, b=0x00000001, op=00. Required: sum=0x00010000, cout=0, ovf=0, zero=0, at latency STAGES. Repeat with a=0xFFFFFFFF, b=1: sum=0, cout=1, zero=1.
- Subtract/overflow: a=0x80000000, b=1, op=01. Required: sum=0x7FFFFFFF, ovf=1, cout=1, neg=0. Also a=0x7FFFFFFF, b=0xFFFFFFFF, op=00: sum=0x7FFFFFFE, ovf=0, cout=1.
- 64-bit chain via carry modes: low words a=0xFFFFFFFF, b=1, op=00 gives cout=1. Then high words a=0, b=0, op=10, cin=1 gives sum=1. Borrow: a=0, b=0, op=11, cin=0 gives sum=0xFFFFFFFF, cout=0.
- Backpressure: stream 10 back-to-back random ops; hold out_ready=0 for 3 cycles mid-stream. Required: in_ready=0 while stalled, outputs stable, no loss or duplication, results in order and equal to the golden model.
- Parameter sweep: random 10k ops with a golden-model compare for (WIDTH, STAGES) = (16,1), (32,2), (32,4), (64,8). Required: zero mismatches and measured latency equal to STAGES.

Source files
------------

// File: rtl/cla_pipe_addsub_if.sv
// ---------------------------------------------------------------------------
// cla_pipe_addsub_if
// Operand/result bundle for the pipelined CLA adder/subtractor.
//   in_valid/in_ready   : operand handshake (producer -> adder)
//   a, b, op, cin       : operands, operation select and carry-in
//   out_valid/out_ready : result handshake (adder -> consumer)
//   sum, cout, ovf,
//   zero, neg           : result word and NZCV-style flags
// The producer/consumer side uses the master modport, the adder uses slave.
// ---------------------------------------------------------------------------
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// ---------------------------------------------------------------------------
// cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operands are cut
// into STAGES slices of SW = WIDTH/STAGES bits. Slice k is resolved in
// pipeline stage k by a two-level (4-bit group, then slice) lookahead adder;
// the carry between slices is registered.
//   op = 00 : a + b
//   op = 01 : a - b
//   op = 10 : a + b + cin
//   op = 11 : a - b - ~cin   (borrow chain, cin=1 means no borrow in)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cla_pipe_addsub_if.slave (operands, result, flags, handshakes)
// Flow control is a whole-pipe stall: every stage advances together when the
// output register is empty or being drained this cycle.
// ---------------------------------------------------------------------------
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_pipe_addsub_if.slave   bus
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  // Two-level lookahead for one slice. Returns {carry_out, sum_bits}.
  function automatic logic [SW:0] cla_slice(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [SW-1:0] c;
    logic [NG-1:0] pg;
    logic [NG-1:0] gg;
    logic [NG-1:0] gc;
    logic          term;
    logic          pg_s;
    logic          gg_s;
    logic          co;
    p  = x ^ y;
    g  = x & y;
    pg = '0;
    gg = '0;
    gc = '0;
    c  = '0;

    // First level: group propagate/generate over each nibble.
    for (int j = 0; j < NG; j++) begin
      pg[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end

    // Second level: carry into every group expanded in sum-of-products form
    // from the slice carry-in, so no group waits on its neighbour.
    for (int j = 0; j < NG; j++) begin
      term = ci;
      for (int i = 0; i < j; i++) begin
        term = term & pg[i];
      end
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) begin
          term = term & pg[m];
        end
        gc[j] = gc[j] | term;
      end
    end

    // Slice-level propagate/generate drive the carry handed to the next slice.
    pg_s = &pg;
    gg_s = 1'b0;
    for (int i = 0; i < NG; i++) begin
      term = gg[i];
      for (int m = i + 1; m < NG; m++) begin
        term = term & pg[m];
      end
      gg_s = gg_s | term;
    end
    co = gg_s | (pg_s & ci);

    // Bit carries inside each group from that group's lookahead carry.
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end

    return {co, p ^ c};
  endfunction

  // Stage registers. Index k holds the state after slice k has resolved:
  // operands (b already conditioned), sum bits 0..k, carry into slice k+1,
  // running zero accumulator and the valid bit.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] z_q;
  logic [STAGES-1:0] vld_q;

  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] z_d;
  logic [STAGES-1:0] vld_d;

  // Inputs seen by each stage's slice: the bus for stage 0, the previous
  // stage register otherwise.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_z;
  logic [STAGES-1:0] src_v;

  logic adv;

  // Stall only when a result is held and the consumer refuses it.
  assign adv          = ~vld_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;

  // ---- stage 0 input: operand conditioning ----
  always_comb begin
    src_a = '{default: '0};
    src_b = '{default: '0};
    src_s = '{default: '0};
    src_c = '0;
    src_z = '0;
    src_v = '0;

    src_a[0] = bus.a;
    src_b[0] = bus.op[0] ? ~bus.b : bus.b;
    src_c[0] = bus.op[1] ? bus.cin : bus.op[0];
    src_s[0] = '0;
    src_z[0] = 1'b1;
    src_v[0] = bus.in_valid;

    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = sum_q[k-1];
      src_c[k] = c_q[k-1];
      src_z[k] = z_q[k-1];
      src_v[k] = vld_q[k-1];
    end
  end

  // ---- per-stage slice evaluation ----
  always_comb begin : p_slices
    logic [SW:0] res;
    res   = '0;
    a_d   = '{default: '0};
    b_d   = '{default: '0};
    sum_d = '{default: '0};
    c_d   = '0;
    z_d   = '0;
    vld_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      res                   = cla_slice(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW], src_c[k]);
      a_d[k]                = src_a[k];
      b_d[k]                = src_b[k];
      sum_d[k]              = src_s[k];
      sum_d[k][k*SW +: SW]  = res[SW-1:0];
      c_d[k]                = res[SW];
      z_d[k]                = src_z[k] & (res[SW-1:0] == '0);
      vld_d[k]              = src_v[k];
    end
  end

  // ---- stage registers: advance as one, or hold as one ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      c_q   <= '0;
      z_q   <= '0;
      vld_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
      c_q   <= c_d;
      z_q   <= z_d;
      vld_q <= vld_d;
    end
  end

  // ---- output stage: result and flags straight from the last register ----
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.zero      = z_q[STAGES-1];
  assign bus.neg       = sum_q[STAGES-1][WIDTH-1];
  // Same-sign operands producing a result of the other sign.
  assign bus.ovf       = (a_q[STAGES-1][WIDTH-1] ~^ b_q[STAGES-1][WIDTH-1])
                       & (sum_q[STAGES-1][WIDTH-1] ^ a_q[STAGES-1][WIDTH-1]);

endmodule
